// File: rtl/c3lib_rst_seq_pkg.sv
// Shared types and limits for the reset release sequencer.
package c3lib_rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DLY  = 3'd1,
    REL  = 3'd2,
    WACK = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } rst_seq_state_e;

  localparam int unsigned RST_SEQ_MAX_STAGES = 8;

endpackage

// File: rtl/c3lib_rst_seq_ack_sync.sv
// Multi-bit, multi-flop synchronizer for the per-domain reset acknowledges.
module c3lib_rst_seq_ack_sync
  import c3lib_rst_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ack_in,
  output logic [WIDTH-1:0] ack_sync
);

  // Row 0 captures the asynchronous input; row DEPTH-1 is the safe output.
  logic [DEPTH-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], ack_in};
    end
  end

  assign ack_sync = sync_q[DEPTH-1];

endmodule

// File: rtl/c3lib_rst_seq_ctrl.sv
// Ordered release of NUM_STAGES reset domains: per-stage delay, release,
// then wait for the domain's acknowledge (optionally bounded by a timeout).
module c3lib_rst_seq_ctrl
  import c3lib_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ACK_SYNC   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          seq_start,
  input  logic [NUM_STAGES*CNT_W-1:0]   stage_dly,
  input  logic [CNT_W-1:0]              ack_tmo,
  input  logic [NUM_STAGES-1:0]         stage_ack,
  output logic [NUM_STAGES-1:0]         stage_rst_n,
  output logic                          seq_busy,
  output logic                          seq_done,
  output logic                          seq_err,
  output logic [$clog2(NUM_STAGES)-1:0] err_stage
);

  localparam int unsigned IDX_W = $clog2(NUM_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  logic [NUM_STAGES-1:0] ack_s;
  logic [CNT_W-1:0]      dly_arr [NUM_STAGES];

  rst_seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      tcnt_q, tcnt_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      err_stage_q, err_stage_d;

  c3lib_rst_seq_ack_sync #(
    .WIDTH(NUM_STAGES),
    .DEPTH(ACK_SYNC)
  ) u_ack_sync (
    .clk      (clk),
    .rst      (rst),
    .ack_in   (stage_ack),
    .ack_sync (ack_s)
  );

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_dly
    assign dly_arr[g] = stage_dly[g*CNT_W +: CNT_W];
  end

  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    rst_n_d     = rst_n_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;

    // Dropping seq_start outranks every other event in the same cycle.
    if (state_q != IDLE && !seq_start) begin
      state_d     = IDLE;
      idx_d       = '0;
      cnt_d       = '0;
      tcnt_d      = '0;
      rst_n_d     = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_stage_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rst_n_d = '0;
          if (seq_start) begin
            state_d     = DLY;
            idx_d       = '0;
            cnt_d       = dly_arr[0];
            busy_d      = 1'b1;
            done_d      = 1'b0;
            err_d       = 1'b0;
            err_stage_d = '0;
          end
        end

        DLY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = REL;
          end
        end

        REL: begin
          rst_n_d[idx_q] = 1'b1;
          tcnt_d         = ack_tmo;
          state_d        = WACK;
        end

        WACK: begin
          // tcnt==0 on entry means no timeout; otherwise the cycle that would
          // bring it to zero without an ack is the timeout cycle.
          if (ack_s[idx_q]) begin
            tcnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              idx_d   = idx_nxt;
              cnt_d   = dly_arr[idx_nxt];
              state_d = DLY;
            end
          end else if (tcnt_q == CNT_W'(1)) begin
            tcnt_d      = '0;
            state_d     = ERR;
            err_d       = 1'b1;
            err_stage_d = idx_q;
            busy_d      = 1'b0;
          end else if (tcnt_q != '0) begin
            tcnt_d = tcnt_q - CNT_W'(1);
          end
        end

        DONE: begin
          state_d = DONE;
        end

        ERR: begin
          state_d = ERR;
        end

        default: begin
          state_d = IDLE;
          rst_n_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      rst_n_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      rst_n_q     <= rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign stage_rst_n = rst_n_q;
  assign seq_busy    = busy_q;
  assign seq_done    = done_q;
  assign seq_err     = err_q;
  assign err_stage   = err_stage_q;

endmodule
